uart_rx: RTL and testbench

//  Serial receive side of the tty UART link: samples the RxD line (8N1, LSB first), rebuilds

---
 rtl/uart_rx.sv | 178 +++++++++++++++++
 tb/tb_uart_rx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 serial receiver: synchronises RxD, samples each bit at its middle using a 16x baud tick,
// and queues good bytes in a small first-word-fall-through FIFO with sticky error flags.
module uart_rx #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_50mhz,
    input  logic       rst,
    input  logic       RxD,
    input  logic       read,
    output logic [7:0] data,
    output logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic [1:0] fsm_state
);

    localparam int DIV = (CLK_HZ + BAUD * 8) / (BAUD * 16);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rxs;
    logic          rx_prev;
    logic [DW-1:0] div_cnt;
    logic [3:0]    tick_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    logic tick;
    logic mid_tick;
    logic bit_tick;
    logic fall;
    logic full;
    logic pop;
    logic push;
    logic wr_en;
    logic ovr_set;
    logic ferr_set;

    assign tick     = (div_cnt == DIV_LAST);
    assign mid_tick = tick && (tick_cnt == 4'd7);
    assign bit_tick = tick && (tick_cnt == 4'd15);
    assign fall     = rx_prev && !rxs;

    assign ready = (wr_ptr != rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign data  = mem[rd_ptr[AW-1:0]];
    assign pop   = read && ready;

    // A full FIFO still accepts the byte when the core pops on the same edge.
    assign push     = (state == STOP) && bit_tick && rxs;
    assign wr_en    = push && (!full || pop);
    assign ovr_set  = push && full && !pop;
    assign ferr_set = (state == STOP) && bit_tick && !rxs;

    assign fsm_state = state;

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RxD;
            rxs     <= rx_meta;
            rx_prev <= rxs;
        end
    end

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            tick_cnt <= 4'd0;
            bit_cnt  <= 3'd0;
            shift    <= 8'h00;
        end else begin
            // Restarting the divider on the start edge puts tick 8 at mid start bit.
            if ((state == IDLE && fall) || tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (fall) begin
                        state    <= START;
                        tick_cnt <= 4'd0;
                    end
                end
                START: begin
                    if (mid_tick) begin
                        tick_cnt <= 4'd0;
                        bit_cnt  <= 3'd0;
                        state    <= rxs ? IDLE : DATA;
                    end else if (tick) begin
                        tick_cnt <= tick_cnt + 4'd1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        tick_cnt <= tick_cnt + 4'd1;
                    end
                    if (bit_tick) begin
                        shift   <= {rxs, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        tick_cnt <= tick_cnt + 4'd1;
                    end
                    if (bit_tick) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= shift;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // A set event outranks the clear caused by read in the same cycle.
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (ferr_set) begin
                frame_err <= 1'b1;
            end else if (read) begin
                frame_err <= 1'b0;
            end
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (read) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives bit-accurate 8N1 frames on RxD and checks bytes and flags
// against a queue-based model of the receive FIFO and its sticky error flags.
module tb_uart_rx;

    localparam int BIT        = 432;
    localparam int FIFO_DEPTH = 4;

    logic       clk_50mhz;
    logic       rst;
    logic       RxD;
    logic       read;
    logic [7:0] data;
    logic       ready;
    logic       frame_err;
    logic       overrun;
    logic [1:0] fsm_state;

    int checks;
    int errors;

    logic [7:0] exp_q[$];
    logic       m_ferr;
    logic       m_ovr;

    typedef struct packed {
        logic [7:0] b;
        logic       stop;
        logic       exp_ready;
        logic       exp_ferr;
    } vec_t;

    vec_t tbl [3];

    uart_rx #(
        .CLK_HZ(50000000),
        .BAUD(115200),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_50mhz(clk_50mhz),
        .rst(rst),
        .RxD(RxD),
        .read(read),
        .data(data),
        .ready(ready),
        .frame_err(frame_err),
        .overrun(overrun),
        .fsm_state(fsm_state)
    );

    // clock / reset
    initial clk_50mhz = 1'b0;
    always #10 clk_50mhz = ~clk_50mhz;

    initial begin
        #2500000;
        $display("FAIL timeout: simulation ran past its time budget");
        $fatal(1, "timeout");
    end

    // checking helpers
    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic check_flags(input string name);
        check({name, "_frame_err"}, {31'd0, frame_err}, {31'd0, m_ferr});
        check({name, "_overrun"}, {31'd0, overrun}, {31'd0, m_ovr});
    endtask

    // driver tasks (called on a falling clock edge)
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        RxD = 1'b0;
        repeat (BIT) @(negedge clk_50mhz);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            repeat (BIT) @(negedge clk_50mhz);
        end
        RxD = stop_bit;
        repeat (BIT) @(negedge clk_50mhz);
        RxD = 1'b1;
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop_bit);
        if (!stop_bit) begin
            m_ferr = 1'b1;
        end else if (exp_q.size() < FIFO_DEPTH) begin
            exp_q.push_back(b);
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop_bit);
        send_frame(b, stop_bit);
        model_frame(b, stop_bit);
        repeat (20) @(negedge clk_50mhz);
    endtask

    task automatic read_pulse();
        read = 1'b1;
        @(negedge clk_50mhz);
        read = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic pop_expect(input string name);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got ready=%0b data=%0h, required a queued byte", name, ready, data);
        end else begin
            e = exp_q.pop_front();
            check({name, "_ready"}, {31'd0, ready}, 32'd1);
            check({name, "_data"}, {24'd0, data}, {24'd0, e});
        end
        read_pulse();
    endtask

    initial begin
        int lat;
        int n_pop;
        logic [7:0] rb;
        logic       rs;

        checks = 0;
        errors = 0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        rst    = 1'b1;
        RxD    = 1'b1;
        read   = 1'b0;

        tbl[0] = '{b: 8'h55, stop: 1'b0, exp_ready: 1'b0, exp_ferr: 1'b1};
        tbl[1] = '{b: 8'h00, stop: 1'b1, exp_ready: 1'b1, exp_ferr: 1'b0};
        tbl[2] = '{b: 8'hFF, stop: 1'b1, exp_ready: 1'b1, exp_ferr: 1'b0};

        // reset state
        repeat (5) @(negedge clk_50mhz);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_data", {24'd0, data}, 32'd0);
        check_flags("rst");
        check("rst_state", {30'd0, fsm_state}, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk_50mhz);

        // 0x41: ready ~9.5 bit times (4104 clocks) plus synchroniser/edge delay after the start edge
        lat = 0;
        fork
            send_frame(8'h41, 1'b1);
            begin
                while (ready !== 1'b1 && lat < 6000) begin
                    @(negedge clk_50mhz);
                    lat++;
                end
            end
        join
        model_frame(8'h41, 1'b1);
        repeat (20) @(negedge clk_50mhz);
        checks++;
        if (lat < 4104 || lat > 4112) begin
            errors++;
            $display("FAIL latency_0x41: got %0d clocks, required 4104..4112", lat);
        end
        pop_expect("byte_0x41");
        check("after_0x41_ready", {31'd0, ready}, 32'd0);

        // start-bit glitch is rejected
        RxD = 1'b0;
        repeat (50) @(negedge clk_50mhz);
        check("glitch_in_start", {30'd0, fsm_state}, 32'd1);
        repeat (50) @(negedge clk_50mhz);
        RxD = 1'b1;
        repeat (400) @(negedge clk_50mhz);
        check("glitch_state", {30'd0, fsm_state}, 32'd0);
        check("glitch_ready", {31'd0, ready}, 32'd0);
        check_flags("glitch");

        // table-driven single frames
        for (int i = 0; i < 3; i++) begin
            send_frame(tbl[i].b, tbl[i].stop);
            repeat (20) @(negedge clk_50mhz);
            check($sformatf("tbl%0d_ready", i), {31'd0, ready}, {31'd0, tbl[i].exp_ready});
            if (tbl[i].exp_ready) begin
                check($sformatf("tbl%0d_data", i), {24'd0, data}, {24'd0, tbl[i].b});
            end
            check($sformatf("tbl%0d_frame_err", i), {31'd0, frame_err}, {31'd0, tbl[i].exp_ferr});
            check($sformatf("tbl%0d_overrun", i), {31'd0, overrun}, 32'd0);
            read_pulse();
            repeat (2) @(negedge clk_50mhz);
            check($sformatf("tbl%0d_ready_after_read", i), {31'd0, ready}, 32'd0);
            check($sformatf("tbl%0d_ferr_after_read", i), {31'd0, frame_err}, 32'd0);
        end

        // overrun: five bytes, no reads
        for (int i = 1; i <= 5; i++) begin
            send(8'(i), 1'b1);
        end
        check_flags("ovr_fill");
        pop_expect("ovr_pop0");
        check_flags("ovr_after_read");
        for (int i = 1; i < 4; i++) begin
            pop_expect($sformatf("ovr_pop%0d", i));
        end
        check("ovr_drained_ready", {31'd0, ready}, 32'd0);

        // full FIFO with a pop on the stop-sample edge of a fifth byte
        for (int i = 1; i <= 4; i++) begin
            send(8'(i), 1'b1);
        end
        fork
            send_frame(8'hA5, 1'b1);
            begin
                // start edge seen 2 clocks late, START entered 1 later, stop sampled 9.5 bits after that
                repeat (4106) @(posedge clk_50mhz);
                @(negedge clk_50mhz);
                check("simul_head", {24'd0, data}, {24'd0, exp_q[0]});
                read = 1'b1;
                @(negedge clk_50mhz);
                read = 1'b0;
            end
        join
        void'(exp_q.pop_front());
        exp_q.push_back(8'hA5);
        repeat (20) @(negedge clk_50mhz);
        check_flags("simul");
        for (int i = 0; i < 4; i++) begin
            pop_expect($sformatf("simul_pop%0d", i));
        end
        check("simul_drained_ready", {31'd0, ready}, 32'd0);

        // reset in DATA bit 3 of 0xF0, released while the line is high
        fork
            send_frame(8'hF0, 1'b1);
            begin
                repeat (BIT * 4 + 200) @(negedge clk_50mhz);
                rst = 1'b1;
                repeat (BIT) @(negedge clk_50mhz);
                rst = 1'b0;
            end
        join
        exp_q.delete();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        repeat (20) @(negedge clk_50mhz);
        check("midrst_ready", {31'd0, ready}, 32'd0);
        check("midrst_state", {30'd0, fsm_state}, 32'd0);
        check_flags("midrst");
        send(8'h7E, 1'b1);
        check_flags("midrst_7e");
        pop_expect("midrst_7e");
        check("midrst_drained_ready", {31'd0, ready}, 32'd0);

        // randomized frames against the scoreboard
        for (int i = 0; i < 3; i++) begin
            rb = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 3) != 0);
            send(rb, rs);
            check_flags($sformatf("rnd%0d", i));
            if ($urandom_range(0, 1) == 1 || i == 2) begin
                n_pop = exp_q.size();
                for (int k = 0; k < n_pop; k++) begin
                    pop_expect($sformatf("rnd%0d_pop%0d", i, k));
                end
                read_pulse();
                repeat (2) @(negedge clk_50mhz);
                check_flags($sformatf("rnd%0d_drained", i));
                check($sformatf("rnd%0d_drained_ready", i), {31'd0, ready}, 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
